// File: rtl/operand_fetch_pkg.sv
// Shared constants and opcode classification for the vector operand-fetch stage.
// Bypass option is selected in operand_fetch.sv via OPFETCH_WB_BYPASS_EN.
package vp_pkg;

  localparam int NREGS     = 8;
  localparam int OPC_W     = 5;
  localparam int REG_IDX_W = 3;
  localparam int MEM_W     = 15;
  localparam int PC_W      = 16;

  localparam logic [OPC_W-1:0] OPC_NOP = 5'b00000;

  typedef enum logic [1:0] {
    CLS_NOP    = 2'd0,
    CLS_WRITER = 2'd1,
    CLS_READER = 2'd2
  } instr_cls_e;

  // Writers are non-NOP opcodes with the top bit clear; all other non-NOPs only read.
  function automatic instr_cls_e classify(input logic [OPC_W-1:0] opc);
    instr_cls_e cls;
    if (opc == OPC_NOP) begin
      cls = CLS_NOP;
    end else if (!opc[OPC_W-1]) begin
      cls = CLS_WRITER;
    end else begin
      cls = CLS_READER;
    end
    return cls;
  endfunction

  function automatic logic writes_reg(input logic [OPC_W-1:0] opc);
    return (classify(opc) == CLS_WRITER);
  endfunction

  function automatic logic reads_reg(input logic [OPC_W-1:0] opc);
    logic r;
    case (classify(opc))
      CLS_NOP:    r = 1'b0;
      CLS_WRITER: r = 1'b1;
      CLS_READER: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction-in, writeback and operand-out bundle of the operand-fetch stage.
// The slave modport is the stage itself; the master modport is its environment.
interface operand_fetch_if
  import vp_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) ();

  localparam int VW = LANES * LANE_W;

  logic                 in_valid;
  logic                 in_ready;
  logic [OPC_W-1:0]     opcode;
  logic [REG_IDX_W-1:0] dirl_brv;
  logic [REG_IDX_W-1:0] dire_brv;
  logic [MEM_W-1:0]     dir_mem;
  logic [PC_W-1:0]      pc_in;

  logic                 wb_en;
  logic [REG_IDX_W-1:0] wb_addr;
  logic [VW-1:0]        wb_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [OPC_W-1:0]     out_opcode;
  logic [REG_IDX_W-1:0] out_dest;
  logic [MEM_W-1:0]     out_dir_mem;
  logic [PC_W-1:0]      out_pc;
  logic [VW-1:0]        out_src;

  modport master (
    output in_valid, opcode, dirl_brv, dire_brv, dir_mem, pc_in,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_dest, out_dir_mem, out_pc, out_src
  );

  modport slave (
    input  in_valid, opcode, dirl_brv, dire_brv, dir_mem, pc_in,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_opcode, out_dest, out_dir_mem, out_pc, out_src
  );

endinterface

// File: rtl/operand_fetch_vreg_file.sv
// Vector register file: one asynchronous read port, one synchronous write port,
// synchronous clear of every entry.
module vreg_file
  import vp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [REG_IDX_W-1:0] raddr,
  output logic [W-1:0]         rdata
);

  logic [W-1:0] regs [NREGS];

  // storage update: clear on reset, otherwise single-port write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: scoreboarded hazard stall, register read, one output register.
// Define OPFETCH_WB_BYPASS_EN to forward same-cycle writeback data instead of stalling.
module operand_fetch
  import vp_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input logic           clk,
  input logic           rst,
  operand_fetch_if.slave bus
);

  localparam int VW = LANES * LANE_W;

  logic [NREGS-1:0]     pending;
  logic [NREGS-1:0]     pending_next;
  logic [VW-1:0]        rf_rdata;
  logic                 is_reader;
  logic                 is_writer;
  logic                 src_byp;
  logic                 dst_byp;
  logic                 hazard;
  logic                 ready;
  logic                 accept;
  logic [VW-1:0]        src_value;

  logic                 out_valid_q;
  logic [OPC_W-1:0]     out_opcode_q;
  logic [REG_IDX_W-1:0] out_dest_q;
  logic [MEM_W-1:0]     out_dir_mem_q;
  logic [PC_W-1:0]      out_pc_q;
  logic [VW-1:0]        out_src_q;

  vreg_file #(.W(VW)) u_vreg_file (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.wb_en),
    .waddr (bus.wb_addr),
    .wdata (bus.wb_data),
    .raddr (bus.dirl_brv),
    .rdata (rf_rdata)
  );

  assign is_reader = reads_reg(bus.opcode);
  assign is_writer = writes_reg(bus.opcode);

  // hazard detection; a writeback landing this cycle can mask a pending bit when bypass is built in
  always_comb begin
    src_byp = 1'b0;
    dst_byp = 1'b0;
    hazard  = 1'b0;
`ifdef OPFETCH_WB_BYPASS_EN
    src_byp = bus.wb_en && (bus.wb_addr == bus.dirl_brv);
    dst_byp = bus.wb_en && (bus.wb_addr == bus.dire_brv);
`endif
    if (bus.in_valid) begin
      hazard = (is_reader && pending[bus.dirl_brv] && !src_byp) ||
               (is_writer && pending[bus.dire_brv] && !dst_byp);
    end else begin
      hazard = 1'b0;
    end
  end

  assign ready        = !rst && (!out_valid_q || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && ready;
  assign bus.in_ready = ready;

  // source operand selection: NOPs carry zero, bypass forwards the writeback bus
  always_comb begin
    src_value = '0;
    if (!is_reader) begin
      src_value = '0;
    end else if (src_byp) begin
      src_value = bus.wb_data;
    end else begin
      src_value = rf_rdata;
    end
  end

  // scoreboard next state: a new writer's set beats a same-index writeback clear
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NREGS; i++) begin
      if (accept && is_writer && (bus.dire_brv == REG_IDX_W'(i))) begin
        pending_next[i] = 1'b1;
      end else if (bus.wb_en && (bus.wb_addr == REG_IDX_W'(i))) begin
        pending_next[i] = 1'b0;
      end else begin
        pending_next[i] = pending[i];
      end
    end
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // output register: load on accept, hold while stalled downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_opcode_q  <= '0;
      out_dest_q    <= '0;
      out_dir_mem_q <= '0;
      out_pc_q      <= '0;
      out_src_q     <= '0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_opcode_q  <= bus.opcode;
      out_dest_q    <= bus.dire_brv;
      out_dir_mem_q <= bus.dir_mem;
      out_pc_q      <= bus.pc_in;
      out_src_q     <= src_value;
    end else if (bus.out_ready) begin
      out_valid_q   <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_q;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_opcode  = out_opcode_q;
  assign bus.out_dest    = out_dest_q;
  assign bus.out_dir_mem = out_dir_mem_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_src     = out_src_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter LANES, default 4, meaning number of vector lanes per register.
REQ-002 Parameter LANE_W, default 8, meaning bits per lane; VW = LANES*LANE_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  decoded instruction present.
REQ-006 in_ready  output  1  stage accepts instruction this cycle.
REQ-007 opcode  input  5  decoded opcode.
REQ-008 dirl_brv  input  3  source vector register index.
REQ-009 dire_brv  input  3  destination vector register index.
REQ-010 dir_mem  input  15  memory address field.
REQ-011 pc_in  input  16  instruction PC.
REQ-012 wb_en  input  1  writeback strobe; wb_addr  input  3; wb_data  input  VW.
REQ-013 out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-014 out_opcode 5, out_dest 3, out_dir_mem 15, out_pc 16, out_src VW  outputs  registered operands.

Function
REQ-015 Transfer on in_valid&&in_ready; output consumed on out_valid&&out_ready.
REQ-016 Latency exactly 1 cycle: accepted instruction appears on outputs next cycle with out_valid=1.
REQ-017 Single output register; in_ready = (!out_valid || out_ready) && !hazard, combinational.
REQ-018 Outputs hold stable while out_valid && !out_ready.
REQ-019 out_valid clears after consumption unless a new instruction is accepted same cycle.
REQ-020 Classes: NOP (opcode 5'b00000) reads/writes nothing; opcode[4]=0 non-NOP writes dire_brv; every non-NOP reads dirl_brv.
REQ-021 Scoreboard: 8 pending bits; set for dire_brv when a writer is accepted; cleared when wb_en for wb_addr.
REQ-022 Same-cycle set and clear of one index: set wins.
REQ-023 hazard = non-NOP with pending[dirl_brv] (RAW) or writer with pending[dire_brv] (WAW).
REQ-024 Register file 8 x VW; written with wb_data on wb_en at clock edge regardless of pending state.
REQ-025 out_src captures register dirl_brv at acceptance; NOP captures 0.
REQ-026 wb_en to non-pending index: write performed, scoreboard unchanged.
REQ-027 in_valid=0: in_ready still reflects REQ-017 with hazard=0.

Reset
REQ-028 rst: out_valid=0, out_opcode/out_dest/out_dir_mem/out_pc/out_src=0, pending=0, all registers=0.
REQ-029 rst wins over accept and wb_en in the same cycle; in-flight output discarded.
REQ-030 in_ready=0 during rst.

Configuration
REQ-031 Macro OPFETCH_WB_BYPASS_EN.
REQ-032 Defined: wb_en with wb_addr matching a pending source/dest ignores that pending bit for hazard; out_src takes wb_data; no stall.
REQ-033 Undefined: such an instruction stalls exactly one cycle, then reads written value from register file.

Structure
REQ-034 Package vp_pkg holds NREGS=8, OPC_W=5, REG_IDX_W=3, MEM_W=15, PC_W=16, OPC_NOP, writes_reg/reads_reg classification functions.
REQ-035 Sub-module vreg_file: 8-entry, 1 async read port, 1 sync write port, sync reset.

Verification
REQ-036 Writer opc=5'h01 dest=2 accepted, then reader src=2 -> in_ready=0 until wb_en addr=2 data=0xA5A5A5A5; out_src=0xA5A5A5A5 (bypass: same cycle; else +1).
REQ-037 out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 with new in_valid -> back-to-back, no bubble.
REQ-038 Two writers to dest=5 consecutively -> second stalls (WAW) until wb_en addr=5; pending[5] then set again.
REQ-039 NOP with src=dest=pending index -> accepted, out_src=0, scoreboard unchanged.
REQ-040 rst asserted while out_valid=1 and pending=8'h0C -> next cycle out_valid=0, pending=0, registers=0.
REQ-041 Writer to 3 accepted same cycle wb_en addr=3 -> pending[3]=1 after edge.
